lsq_fwd: RTL

- Parametrised load/store queue for the out-of-order core. Sits between issue, CDB and the data memory.
- Loads and stores arrive with fully computed addresses from an external AGU.
- A load at the LQ head may dispatch past older stores to different addresses. Otherwise it forwards from the youngest older matching store.
- Stores commit in order once non-speculative. On branch failure, speculative stores and all loads are squashed.

---
 rtl/lsq_fwd.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsq_fwd.sv
// lsq_fwd: load/store queue with store-to-load forwarding, in-order store
// commit to data memory, and squash of speculative work on branch failure.
module lsq_fwd #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int TAG_WIDTH  = 5,
  parameter int LQ_DEPTH   = 4,
  parameter int SQ_DEPTH   = 8,
  parameter int B_WIDTH    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      iss_valid,
  output logic                      iss_ready,
  input  logic                      iss_is_store,
  input  logic [ADDR_WIDTH-1:0]     iss_addr,
  input  logic [TAG_WIDTH-1:0]      iss_tag,
  input  logic                      iss_data_valid,
  input  logic [DATA_WIDTH-1:0]     iss_data,
  input  logic [TAG_WIDTH-1:0]      iss_data_tag,
  input  logic [B_WIDTH-1:0]        iss_b_count,
  input  logic                      cdb_valid,
  input  logic [TAG_WIDTH-1:0]      cdb_tag,
  input  logic [DATA_WIDTH-1:0]     cdb_data,
  input  logic                      b_commit,
  input  logic                      failure,
  output logic                      ld_req_valid,
  input  logic                      ld_req_ready,
  output logic [TAG_WIDTH-1:0]      ld_tag,
  output logic [DATA_WIDTH-1:0]     ld_result,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_waddr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [ADDR_WIDTH-1:0]     mem_raddr,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      sq_empty,
  output logic [$clog2(LQ_DEPTH):0] lq_count,
  output logic [$clog2(SQ_DEPTH):0] sq_count
);
  localparam int LQ_AW = $clog2(LQ_DEPTH);
  localparam int SQ_AW = $clog2(SQ_DEPTH);
  localparam int LQ_CW = LQ_AW + 1;
  localparam int SQ_CW = SQ_AW + 1;

  // Load queue storage and pointers
  logic [ADDR_WIDTH-1:0] lq_addr_q [LQ_DEPTH];
  logic [ADDR_WIDTH-1:0] lq_addr_d [LQ_DEPTH];
  logic [TAG_WIDTH-1:0]  lq_tag_q  [LQ_DEPTH];
  logic [TAG_WIDTH-1:0]  lq_tag_d  [LQ_DEPTH];
  logic [SQ_CW-1:0]      lq_old_q  [LQ_DEPTH];
  logic [SQ_CW-1:0]      lq_old_d  [LQ_DEPTH];
  logic [LQ_AW-1:0]      lq_head_q, lq_head_d, lq_tail_q, lq_tail_d;
  logic [LQ_CW-1:0]      lq_cnt_q, lq_cnt_d;

  // Store queue storage and pointers
  logic [ADDR_WIDTH-1:0] sq_addr_q [SQ_DEPTH];
  logic [ADDR_WIDTH-1:0] sq_addr_d [SQ_DEPTH];
  logic [DATA_WIDTH-1:0] sq_data_q [SQ_DEPTH];
  logic [DATA_WIDTH-1:0] sq_data_d [SQ_DEPTH];
  logic                  sq_dv_q   [SQ_DEPTH];
  logic                  sq_dv_d   [SQ_DEPTH];
  logic [TAG_WIDTH-1:0]  sq_dtag_q [SQ_DEPTH];
  logic [TAG_WIDTH-1:0]  sq_dtag_d [SQ_DEPTH];
  logic [B_WIDTH-1:0]    sq_b_q    [SQ_DEPTH];
  logic [B_WIDTH-1:0]    sq_b_d    [SQ_DEPTH];
  logic [SQ_AW-1:0]      sq_head_q, sq_head_d, sq_tail_q, sq_tail_d;
  logic [SQ_CW-1:0]      sq_cnt_q, sq_cnt_d;

  // Load result and last memory write (read-during-write bypass)
  logic [DATA_WIDTH-1:0] ld_result_q, ld_result_d;
  logic                  last_we_q, last_we_d;
  logic [ADDR_WIDTH-1:0] last_waddr_q, last_waddr_d;
  logic [DATA_WIDTH-1:0] last_wdata_q, last_wdata_d;

  // Control decode
  logic [ADDR_WIDTH-1:0] lq_head_addr_s;
  logic [SQ_AW-1:0]      sq_idx_s;
  logic [LQ_AW-1:0]      lq_nidx_s;
  logic                  fwd_hit_s, fwd_dv_s, bypass_s, keep_run_s;
  logic [DATA_WIDTH-1:0] fwd_data_s, ld_data_s;
  logic                  grant_s, commit_s, st_fire_s, ld_fire_s;
  logic [SQ_CW-1:0]      sq_keep_s;

  assign ld_tag    = lq_tag_q[lq_head_q];
  assign ld_result = ld_result_q;
  assign mem_we    = commit_s;
  assign mem_waddr = sq_addr_q[sq_head_q];
  assign mem_wdata = sq_data_q[sq_head_q];
  assign lq_count  = lq_cnt_q;
  assign sq_count  = sq_cnt_q;
  assign sq_empty  = (sq_cnt_q == '0);

  // Forwarding search, handshakes, commit, read address and squash prefix
  always_comb begin
    lq_head_addr_s = lq_addr_q[lq_head_q];
    sq_idx_s       = sq_head_q;
    fwd_hit_s      = 1'b0;
    fwd_dv_s       = 1'b0;
    fwd_data_s     = '0;
    // Later (younger) matches override earlier ones
    for (int i = 0; i < SQ_DEPTH; i++) begin
      sq_idx_s = sq_head_q + SQ_AW'(i);
      if ((SQ_CW'(i) < lq_old_q[lq_head_q]) && (sq_addr_q[sq_idx_s] == lq_head_addr_s)) begin
        fwd_hit_s  = 1'b1;
        fwd_dv_s   = sq_dv_q[sq_idx_s];
        fwd_data_s = sq_data_q[sq_idx_s];
      end else begin
        fwd_hit_s  = fwd_hit_s;
      end
    end
    bypass_s = last_we_q && (last_waddr_q == lq_head_addr_s);
    if (fwd_hit_s) begin
      ld_data_s = fwd_data_s;
    end else if (bypass_s) begin
      ld_data_s = last_wdata_q;
    end else begin
      ld_data_s = mem_rdata;
    end
    ld_req_valid = !reset && (lq_cnt_q != '0) && !(fwd_hit_s && !fwd_dv_s);
    grant_s      = ld_req_valid && ld_req_ready && !failure;
    commit_s     = !reset && (sq_cnt_q != '0) && (sq_b_q[sq_head_q] == '0) && sq_dv_q[sq_head_q];
    if (reset || failure) begin
      iss_ready = 1'b0;
    end else if (iss_is_store) begin
      iss_ready = (sq_cnt_q < SQ_CW'(SQ_DEPTH)) || commit_s;
    end else begin
      iss_ready = (lq_cnt_q < LQ_CW'(LQ_DEPTH)) || grant_s;
    end
    st_fire_s = iss_valid && iss_ready && iss_is_store;
    ld_fire_s = iss_valid && iss_ready && !iss_is_store;
    // Present next cycle's head address so its read data lands in time
    lq_nidx_s = lq_head_q + LQ_AW'(grant_s);
    if (lq_cnt_q > LQ_CW'(grant_s)) begin
      mem_raddr = lq_addr_q[lq_nidx_s];
    end else if (ld_fire_s) begin
      mem_raddr = iss_addr;
    end else begin
      mem_raddr = lq_head_addr_s;
    end
    // Non-speculative stores form a prefix from the head
    sq_keep_s  = '0;
    keep_run_s = 1'b1;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      sq_idx_s = sq_head_q + SQ_AW'(i);
      if (keep_run_s && (SQ_CW'(i) < sq_cnt_q) && (sq_b_q[sq_idx_s] == '0)) begin
        sq_keep_s = sq_keep_s + SQ_CW'(1);
      end else begin
        keep_run_s = 1'b0;
      end
    end
  end

  // Load queue next state: enqueue, older-store aging, pop, flush
  always_comb begin
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (ld_fire_s && (lq_tail_q == LQ_AW'(i))) begin
        lq_addr_d[i] = iss_addr;
        lq_tag_d[i]  = iss_tag;
        lq_old_d[i]  = sq_cnt_q - SQ_CW'(commit_s);
      end else begin
        lq_addr_d[i] = lq_addr_q[i];
        lq_tag_d[i]  = lq_tag_q[i];
        if (commit_s && (lq_old_q[i] != '0)) begin
          lq_old_d[i] = lq_old_q[i] - SQ_CW'(1);
        end else begin
          lq_old_d[i] = lq_old_q[i];
        end
      end
    end
    lq_head_d = lq_head_q + LQ_AW'(grant_s);
    if (failure) begin
      lq_tail_d = lq_head_d;
      lq_cnt_d  = '0;
    end else begin
      lq_tail_d = lq_tail_q + LQ_AW'(ld_fire_s);
      lq_cnt_d  = lq_cnt_q + LQ_CW'(ld_fire_s) - LQ_CW'(grant_s);
    end
  end

  // Store queue next state: enqueue, CDB capture, branch aging, commit, squash
  always_comb begin
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (st_fire_s && (sq_tail_q == SQ_AW'(i))) begin
        sq_addr_d[i] = iss_addr;
        sq_dtag_d[i] = iss_data_tag;
        sq_b_d[i]    = iss_b_count;
        if (iss_data_valid) begin
          sq_dv_d[i]   = 1'b1;
          sq_data_d[i] = iss_data;
        end else if (cdb_valid && (cdb_tag == iss_data_tag)) begin
          sq_dv_d[i]   = 1'b1;
          sq_data_d[i] = cdb_data;
        end else begin
          sq_dv_d[i]   = 1'b0;
          sq_data_d[i] = iss_data;
        end
      end else begin
        sq_addr_d[i] = sq_addr_q[i];
        sq_dtag_d[i] = sq_dtag_q[i];
        if (b_commit && (sq_b_q[i] != '0)) begin
          sq_b_d[i] = sq_b_q[i] - B_WIDTH'(1);
        end else begin
          sq_b_d[i] = sq_b_q[i];
        end
        if (!sq_dv_q[i] && cdb_valid && (cdb_tag == sq_dtag_q[i])) begin
          sq_dv_d[i]   = 1'b1;
          sq_data_d[i] = cdb_data;
        end else begin
          sq_dv_d[i]   = sq_dv_q[i];
          sq_data_d[i] = sq_data_q[i];
        end
      end
    end
    sq_head_d = sq_head_q + SQ_AW'(commit_s);
    if (failure) begin
      sq_cnt_d  = sq_keep_s - SQ_CW'(commit_s);
      sq_tail_d = sq_head_q + sq_keep_s[SQ_AW-1:0];
    end else begin
      sq_cnt_d  = sq_cnt_q + SQ_CW'(st_fire_s) - SQ_CW'(commit_s);
      sq_tail_d = sq_tail_q + SQ_AW'(st_fire_s);
    end
  end

  // Load result capture and last-write record for the bypass
  always_comb begin
    if (grant_s) begin
      ld_result_d = ld_data_s;
    end else begin
      ld_result_d = ld_result_q;
    end
    last_we_d    = commit_s;
    last_waddr_d = sq_addr_q[sq_head_q];
    last_wdata_d = sq_data_q[sq_head_q];
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      lq_head_q   <= '0;
      lq_tail_q   <= '0;
      lq_cnt_q    <= '0;
      sq_head_q   <= '0;
      sq_tail_q   <= '0;
      sq_cnt_q    <= '0;
      ld_result_q <= '0;
      last_we_q   <= 1'b0;
    end else begin
      lq_head_q   <= lq_head_d;
      lq_tail_q   <= lq_tail_d;
      lq_cnt_q    <= lq_cnt_d;
      sq_head_q   <= sq_head_d;
      sq_tail_q   <= sq_tail_d;
      sq_cnt_q    <= sq_cnt_d;
      ld_result_q <= ld_result_d;
      last_we_q   <= last_we_d;
    end
  end

  // Queue payload storage; entries beyond the counts are don't-care
  always_ff @(posedge clk) begin
    lq_addr_q    <= lq_addr_d;
    lq_tag_q     <= lq_tag_d;
    lq_old_q     <= lq_old_d;
    sq_addr_q    <= sq_addr_d;
    sq_data_q    <= sq_data_d;
    sq_dv_q      <= sq_dv_d;
    sq_dtag_q    <= sq_dtag_d;
    sq_b_q       <= sq_b_d;
    last_waddr_q <= last_waddr_d;
    last_wdata_q <= last_wdata_d;
  end
endmodule
